// File: rtl/redun_from_conv.sv
// Resolves a redundant operand (NUM_WRDS words of WRD_BITS+1 bits, word i
// weighted 2^(i*WRD_BITS)) into canonical binary, WRDS_PER_CYC words per clock.

module redun_from_conv_lane #(
  parameter int WRD_BITS = 16
) (
  input  logic [WRD_BITS:0]   wrd,
  input  logic [1:0]          c_in,
  output logic [WRD_BITS-1:0] res,
  output logic [1:0]          c_out
);
  logic [WRD_BITS+1:0] s;

  assign s     = {1'b0, wrd} + {{WRD_BITS{1'b0}}, c_in};
  assign res   = s[WRD_BITS-1:0];
  assign c_out = s[WRD_BITS+1:WRD_BITS];
endmodule

module redun_from_conv #(
  parameter int WRD_BITS     = 16,
  parameter int NUM_WRDS     = 65,
  parameter int WRDS_PER_CYC = 5
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]     i_dat,
  input  logic                                 i_val,
  output logic                                 o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]         o_dat,
  output logic                                 o_ovf,
  output logic                                 o_val,
  input  logic                                 i_rdy
);
  localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
  localparam int IW       = WRD_BITS + 1;
  localparam int NUM_GRPS = NUM_WRDS / WRDS_PER_CYC;
  localparam int GRP_IN   = WRDS_PER_CYC * IW;
  localparam int GRP_OUT  = WRDS_PER_CYC * WRD_BITS;
  localparam int CNT_W    = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (NUM_WRDS % WRDS_PER_CYC != 0) begin : g_bad_cfg
    $fatal(1, "NUM_WRDS must be a multiple of WRDS_PER_CYC");
  end

  logic [1:0]                              state;
  logic [NUM_WRDS*IW-1:0]                  opnd;
  logic [1:0]                              carry;
  logic [CNT_W-1:0]                        cnt;
  logic [WRDS_PER_CYC:0][1:0]              cch;
  logic [WRDS_PER_CYC-1:0][WRD_BITS-1:0]   grp_res;
  logic [DAT_BITS+GRP_OUT-1:0]             res_cat;
  logic                                    last_grp;

  // The operand register shifts down a group per cycle, so lanes always
  // see its lowest words; results enter o_dat from the top.
  assign cch[0] = carry;
  for (genvar k = 0; k < WRDS_PER_CYC; k++) begin : g_lane
    redun_from_conv_lane #(.WRD_BITS(WRD_BITS)) u_lane (
      .wrd   (opnd[k*IW +: IW]),
      .c_in  (cch[k]),
      .res   (grp_res[k]),
      .c_out (cch[k+1])
    );
  end

  assign res_cat  = {grp_res, o_dat};
  assign last_grp = (cnt == CNT_W'(NUM_GRPS - 1));
  assign o_rdy    = (state == S_IDLE);
  assign o_val    = (state == S_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      opnd  <= '0;
      carry <= '0;
      cnt   <= '0;
      o_dat <= '0;
      o_ovf <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_val) begin
          opnd  <= i_dat;
          carry <= '0;
          cnt   <= '0;
          state <= S_BUSY;
        end
        S_BUSY: begin
          opnd  <= opnd >> GRP_IN;
          carry <= cch[WRDS_PER_CYC];
          cnt   <= cnt + CNT_W'(1);
          o_dat <= res_cat[DAT_BITS+GRP_OUT-1:GRP_OUT];
          if (last_grp) begin
            o_ovf <= (cch[WRDS_PER_CYC] != 2'd0);
            state <= S_DONE;
          end
        end
        S_DONE: if (i_rdy) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_redun_from_conv.sv
// Directed bench for redun_from_conv: reset, boundary operands, hold, abort
// and a batch of random operands against a wide-sum reference.
module tb_redun_from_conv;
  localparam int W    = 16;
  localparam int N    = 65;
  localparam int IW   = W + 1;
  localparam int IN_W = N * IW;
  localparam int DB   = N * W;
  localparam int LAT  = 14;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [IN_W-1:0] i_dat = '0;
  logic            i_val = 1'b0;
  logic            o_rdy;
  logic [DB-1:0]   o_dat;
  logic            o_ovf;
  logic            o_val;
  logic            i_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  redun_from_conv #(.WRD_BITS(W), .NUM_WRDS(N), .WRDS_PER_CYC(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_dat (i_dat),
    .i_val (i_val),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_ovf (o_ovf),
    .o_val (o_val),
    .i_rdy (i_rdy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    int p;
    logic [DB-1:0] a_s, e_s;
    checks++;
    if (act !== exp) begin
      errors++;
      p = 0;
      for (int i = DB - 1; i >= 0; i--) if (act[i] !== exp[i]) p = i;
      a_s = act >> (p & ~63);
      e_s = exp >> (p & ~63);
      $display("FAIL %s first_bad_bit %0d got %h exp %h", tag, p, a_s[63:0], e_s[63:0]);
    end
  endtask

  // Reference: plain weighted sum of the words in a wide accumulator.
  task automatic from_redun(input logic [IN_W-1:0] d, output logic [DB-1:0] r, output logic ov);
    logic [DB+7:0] acc;
    logic [DB+7:0] w;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      w   = '0;
      w[IW-1:0] = d[i*IW +: IW];
      acc = acc + (w << (i * W));
    end
    r  = acc[DB-1:0];
    ov = (acc[DB+7:DB] != 8'd0);
  endtask

  task automatic convert(input string tag, input logic [IN_W-1:0] d, input int hold,
                         input logic [DB-1:0] exp_dat, input logic exp_ovf);
    int lat, wait_cnt;
    logic [DB-1:0] held;
    @(negedge i_clk);
    wait_cnt = 0;
    while (!o_rdy && wait_cnt < 40) begin @(negedge i_clk); wait_cnt++; end
    chk({tag, "_rdy"}, DB'(o_rdy), DB'(1));
    i_dat = d;
    i_val = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_val = 1'b1;
    i_dat = ~d;
    lat = 1;
    while (!o_val && lat < 40) begin @(negedge i_clk); lat++; end
    i_val = 1'b0;
    chk({tag, "_lat"}, DB'(lat), DB'(LAT));
    chk({tag, "_dat"}, o_dat, exp_dat);
    chk({tag, "_ovf"}, DB'(o_ovf), DB'(exp_ovf));
    held = o_dat;
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      chk({tag, "_hold_val"}, DB'(o_val), DB'(1));
      chk({tag, "_hold_dat"}, o_dat, held);
    end
    i_rdy = 1'b1;
    chk({tag, "_done_nordy"}, DB'(o_rdy), DB'(0));
    @(negedge i_clk);
    i_rdy = 1'b0;
    chk({tag, "_post_val"}, DB'(o_val), DB'(0));
    chk({tag, "_post_rdy"}, DB'(o_rdy), DB'(1));
  endtask

  initial begin
    logic [IN_W-1:0] d;
    logic [DB-1:0]   e;
    logic            ov;
    int              vcnt;

    // Reset with i_val asserted must be ignored.
    i_val = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_rdy", DB'(o_rdy), DB'(1));
    chk("rst_val", DB'(o_val), DB'(0));
    chk("rst_ovf", DB'(o_ovf), DB'(0));
    chk("rst_dat", o_dat, '0);
    i_val = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("idle_rdy", DB'(o_rdy), DB'(1));

    convert("zero", '0, 0, '0, 1'b0);

    d = '0; d[IW-1:0] = 17'h1FFFF;
    e = '0; e[IW-1:0] = 17'h1FFFF;
    convert("w0max", d, 0, e, 1'b0);

    for (int i = 0; i < N; i++) d[i*IW +: IW] = 17'h10000;
    e = '0;
    for (int i = 1; i < N; i++) e[i*W +: W] = 16'h0001;
    convert("all10000", d, 0, e, 1'b1);

    // Carry of 2 ripples through every word.
    for (int i = 0; i < N; i++) d[i*IW +: IW] = 17'h1FFFF;
    e = '0;
    e[W-1:0] = 16'hFFFF;
    for (int i = 2; i < N; i++) e[i*W +: W] = 16'h0001;
    convert("all1ffff", d, 5, e, 1'b1);

    // Abort at cycle 6 of BUSY.
    for (int i = 0; i < N; i++) d[i*IW +: IW] = 17'(i * 977 + 5);
    @(negedge i_clk);
    i_dat = d; i_val = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_val = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort_rdy", DB'(o_rdy), DB'(1));
    chk("abort_dat", o_dat, '0);
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_val) vcnt++;
    end
    chk("abort_noval", DB'(vcnt), DB'(0));
    from_redun(d, e, ov);
    convert("after_abort", d, 0, e, ov);

    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < N; i++) d[i*IW +: IW] = 17'($urandom);
      from_redun(d, e, ov);
      convert("rand", d, (t == 0) ? 5 : 0, e, ov);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
